// File: rtl/ext_mem_responder_if.sv
// EXT bus between the memory controller (master) and the external-memory responder (slave).
// OUT_err is present only when EXTMEM_BOUNDS_CHECK_EN is defined.
interface ext_mem_responder_if;
  logic        IN_EXT_en;
  logic [31:0] IN_EXT_bus;
  logic [31:0] OUT_EXT_bus;
  logic        OUT_EXT_oen;
  logic        OUT_busy;
`ifdef EXTMEM_BOUNDS_CHECK_EN
  logic        OUT_err;

  modport master (
    output IN_EXT_en, IN_EXT_bus,
    input  OUT_EXT_bus, OUT_EXT_oen, OUT_busy, OUT_err
  );
  modport slave (
    input  IN_EXT_en, IN_EXT_bus,
    output OUT_EXT_bus, OUT_EXT_oen, OUT_busy, OUT_err
  );
`else
  modport master (
    output IN_EXT_en, IN_EXT_bus,
    input  OUT_EXT_bus, OUT_EXT_oen, OUT_busy
  );
  modport slave (
    input  IN_EXT_en, IN_EXT_bus,
    output OUT_EXT_bus, OUT_EXT_oen, OUT_busy
  );
`endif
endinterface

// File: rtl/ext_mem_responder.sv
// External-memory responder: command decode, wrapped write/read bursts into a word array; EXTMEM_BOUNDS_CHECK_EN adds sticky out-of-range error.
// Read data from cycle N+2 after the command, one word per cycle; no backpressure, dropping IN_EXT_en aborts the burst.
module ext_mem_responder #(
  parameter int WORDS     = 16384,
  parameter int BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst,
  ext_mem_responder_if.slave ext
);
  localparam int AW = $clog2(WORDS);
  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic [2:0] {IDLE, WRITE, RD_TURN, READ, RD_END} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [BW-1:0] cnt;
  logic          oen_q;
  logic          busy_q;
  logic [31:0]   rd_dat;
  logic [31:0]   mem [WORDS];
  logic [BW-1:0] rd_off;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          wr_en;
  logic          last;

`ifdef EXTMEM_BOUNDS_CHECK_EN
  logic oob;
  logic err_q;
  logic cmd_oob;
  logic unused_cmd_bits;

  assign cmd_oob         = {2'b00, ext.IN_EXT_bus[29:0]} >= 32'(WORDS);
  assign unused_cmd_bits = ext.IN_EXT_bus[30];
  assign ext.OUT_err     = err_q;
`else
  logic unused_cmd_bits;

  assign unused_cmd_bits = ^{ext.IN_EXT_bus[30], ext.IN_EXT_bus[29:AW]};
`endif

  // Critical-word-first: only the low BW bits advance, so the burst wraps inside its aligned block.
  assign rd_off = (state == READ) ? cnt + BW'(1) : cnt;
  assign wr_idx = {addr[AW-1:BW], addr[BW-1:0] + cnt};
  assign rd_idx = {addr[AW-1:BW], addr[BW-1:0] + rd_off};
  assign last   = (cnt == BW'(BURST_LEN - 1));

`ifdef EXTMEM_BOUNDS_CHECK_EN
  assign wr_en = (state == WRITE) && ext.IN_EXT_en && !oob;
`else
  assign wr_en = (state == WRITE) && ext.IN_EXT_en;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      oen_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef EXTMEM_BOUNDS_CHECK_EN
      oob    <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else if (state != IDLE && !ext.IN_EXT_en) begin
      state  <= IDLE;
      cnt    <= '0;
      oen_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ext.IN_EXT_en) begin
            addr   <= ext.IN_EXT_bus[AW-1:0];
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ext.IN_EXT_bus[31] ? WRITE : RD_TURN;
`ifdef EXTMEM_BOUNDS_CHECK_EN
            oob    <= cmd_oob;
            if (cmd_oob) err_q <= 1'b1;
`endif
          end
        end
        WRITE: begin
          if (last) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + BW'(1);
          end
        end
        RD_TURN: begin
          state <= READ;
          oen_q <= 1'b1;
        end
        READ: begin
          if (last) begin
            state <= RD_END;
            cnt   <= '0;
            oen_q <= 1'b0;
          end else begin
            cnt <= cnt + BW'(1);
          end
        end
        RD_END: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          oen_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset so it maps onto block RAM; the read port runs one word ahead of the bus.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= ext.IN_EXT_bus;
    rd_dat <= mem[rd_idx];
  end

  assign ext.OUT_EXT_oen = oen_q & ext.IN_EXT_en;
  assign ext.OUT_busy    = busy_q;
`ifdef EXTMEM_BOUNDS_CHECK_EN
  assign ext.OUT_EXT_bus = (oen_q && !oob) ? rd_dat : 32'h0;
`else
  assign ext.OUT_EXT_bus = oen_q ? rd_dat : 32'h0;
`endif
endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed per-cycle vectors for ext_mem_responder (WORDS=16384, BURST_LEN=4) plus an async-reset sequence.
module tb_ext_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ext_mem_responder_if ext();

  ext_mem_responder #(.WORDS(16384), .BURST_LEN(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .ext (ext)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] dat;
    logic        oen;
    logic [31:0] bus;
    logic        busy;
  } vec_t;

  vec_t vec[$];

  task automatic v(input logic en, input logic [31:0] dat, input logic oen,
                   input logic [31:0] bus, input logic busy);
    vec.push_back('{en, dat, oen, bus, busy});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] dat);
    @(negedge clk);
    ext.IN_EXT_en  = en;
    ext.IN_EXT_bus = dat;
    #1;
  endtask

  initial begin
    // write 0x10 <- 11,22,33,44
    v(1, 32'h80000010, 0, 0, 0);
    v(1, 32'h11, 0, 0, 1); v(1, 32'h22, 0, 0, 1); v(1, 32'h33, 0, 0, 1); v(1, 32'h44, 0, 0, 1);
    v(0, 0, 0, 0, 0);
    // read 0x10, then read 0x12 at the earliest legal cycle
    v(1, 32'h10, 0, 0, 0); v(1, 32'hDEADBEEF, 0, 0, 1);
    v(1, 0, 1, 32'h11, 1); v(1, 0, 1, 32'h22, 1); v(1, 0, 1, 32'h33, 1); v(1, 0, 1, 32'h44, 1);
    v(1, 0, 0, 0, 1);
    v(1, 32'h12, 0, 0, 0); v(1, 0, 0, 0, 1);
    v(1, 0, 1, 32'h33, 1); v(1, 0, 1, 32'h44, 1); v(1, 0, 1, 32'h11, 1); v(1, 0, 1, 32'h22, 1);
    v(1, 32'hFFFFFFFF, 0, 0, 1);
    v(0, 0, 0, 0, 0);
    // read aborted in N+3, new read accepted in N+4
    v(1, 32'h10, 0, 0, 0); v(1, 0, 0, 0, 1); v(1, 0, 1, 32'h11, 1);
    v(0, 0, 0, 0, 1);
    v(1, 32'h11, 0, 0, 0); v(1, 0, 0, 0, 1);
    v(1, 0, 1, 32'h22, 1); v(1, 0, 1, 32'h33, 1); v(1, 0, 1, 32'h44, 1); v(1, 0, 1, 32'h11, 1);
    v(0, 0, 0, 0, 1); v(0, 0, 0, 0, 0);
    // write (bit 30 set) back-to-back with read of the same block
    v(1, 32'hC0000020, 0, 0, 0);
    v(1, 32'hA1, 0, 0, 1); v(1, 32'hA2, 0, 0, 1); v(1, 32'hA3, 0, 0, 1); v(1, 32'hA4, 0, 0, 1);
    v(1, 32'h20, 0, 0, 0); v(1, 0, 0, 0, 1);
    v(1, 0, 1, 32'hA1, 1); v(1, 0, 1, 32'hA2, 1); v(1, 0, 1, 32'hA3, 1); v(1, 0, 1, 32'hA4, 1);
    v(0, 0, 0, 0, 1); v(0, 0, 0, 0, 0);
    // write aborted after two words; those two remain
    v(1, 32'h80000030, 0, 0, 0); v(1, 32'hC0, 0, 0, 1); v(1, 32'hC1, 0, 0, 1);
    v(0, 0, 0, 0, 1);
    v(1, 32'h30, 0, 0, 0); v(1, 0, 0, 0, 1); v(1, 0, 1, 32'hC0, 1); v(1, 0, 1, 32'hC1, 1);
    v(0, 0, 0, 0, 1); v(0, 0, 0, 0, 0);
`ifdef EXTMEM_BOUNDS_CHECK_EN
    // out-of-range write is dropped; 0x10 unchanged, out-of-range read returns zeros
    v(1, 32'h80004012, 0, 0, 0);
    v(1, 32'hB0, 0, 0, 1); v(1, 32'hB1, 0, 0, 1); v(1, 32'hB2, 0, 0, 1); v(1, 32'hB3, 0, 0, 1);
    v(1, 32'h10, 0, 0, 0); v(1, 0, 0, 0, 1);
    v(1, 0, 1, 32'h11, 1); v(1, 0, 1, 32'h22, 1); v(1, 0, 1, 32'h33, 1); v(1, 0, 1, 32'h44, 1);
    v(0, 0, 0, 0, 1);
    v(1, 32'h4012, 0, 0, 0); v(1, 0, 0, 0, 1);
    v(1, 0, 1, 32'h0, 1); v(1, 0, 1, 32'h0, 1); v(1, 0, 1, 32'h0, 1); v(1, 0, 1, 32'h0, 1);
    v(0, 0, 0, 0, 1); v(0, 0, 0, 0, 0);
`else
    // 0x4002 aliases to 0x0002; wrapped write order read back from 0x0000
    v(1, 32'h80004002, 0, 0, 0);
    v(1, 32'hB0, 0, 0, 1); v(1, 32'hB1, 0, 0, 1); v(1, 32'hB2, 0, 0, 1); v(1, 32'hB3, 0, 0, 1);
    v(1, 32'h0, 0, 0, 0); v(1, 0, 0, 0, 1);
    v(1, 0, 1, 32'hB2, 1); v(1, 0, 1, 32'hB3, 1); v(1, 0, 1, 32'hB0, 1); v(1, 0, 1, 32'hB1, 1);
    v(0, 0, 0, 0, 1); v(0, 0, 0, 0, 0);
`endif

    ext.IN_EXT_en  = 1'b0;
    ext.IN_EXT_bus = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_oen", {31'b0, ext.OUT_EXT_oen}, 32'h0);
    chk("rst_bus", ext.OUT_EXT_bus, 32'h0);
    chk("rst_busy", {31'b0, ext.OUT_busy}, 32'h0);
`ifdef EXTMEM_BOUNDS_CHECK_EN
    chk("rst_err", {31'b0, ext.OUT_err}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].en, vec[i].dat);
      chk($sformatf("r%0d_oen", i), {31'b0, ext.OUT_EXT_oen}, {31'b0, vec[i].oen});
      chk($sformatf("r%0d_busy", i), {31'b0, ext.OUT_busy}, {31'b0, vec[i].busy});
      if (vec[i].oen) chk($sformatf("r%0d_bus", i), ext.OUT_EXT_bus, vec[i].bus);
    end

`ifdef EXTMEM_BOUNDS_CHECK_EN
    chk("err_sticky", {31'b0, ext.OUT_err}, 32'h1);
`endif

    // reset asserted mid-read releases the bus immediately and returns to IDLE
    drive(1, 32'h10);
    drive(1, 32'h0);
    drive(1, 32'h0);
    chk("mr_word0", ext.OUT_EXT_bus, 32'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_oen", {31'b0, ext.OUT_EXT_oen}, 32'h0);
    chk("mr_bus", ext.OUT_EXT_bus, 32'h0);
    chk("mr_busy", {31'b0, ext.OUT_busy}, 32'h0);
`ifdef EXTMEM_BOUNDS_CHECK_EN
    chk("mr_err", {31'b0, ext.OUT_err}, 32'h0);
`endif
    @(negedge clk);
    ext.IN_EXT_en = 1'b0;
    rst_n = 1'b1;
    drive(0, 32'h0);
    chk("mr_idle", {31'b0, ext.OUT_busy}, 32'h0);
    drive(1, 32'h12);
    chk("mr_cmd_busy", {31'b0, ext.OUT_busy}, 32'h0);
    drive(1, 32'h0);
    chk("mr_turn_oen", {31'b0, ext.OUT_EXT_oen}, 32'h0);
    drive(1, 32'h0);
    chk("mr_rd_oen", {31'b0, ext.OUT_EXT_oen}, 32'h1);
    chk("mr_rd_word0", ext.OUT_EXT_bus, 32'h33);
    drive(0, 32'h0);
    drive(0, 32'h0);
    chk("mr_end_busy", {31'b0, ext.OUT_busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
